// File: rtl/demux_1to8_buffered_pkg.sv
// demux_1to8_buffered_pkg: shared slot count, select/occupancy widths and slot slice offset helper
package demux_1to8_buffered_pkg;
  localparam int NUM_SLOTS = 8;
  localparam int SLT_W = 3;
  localparam int OCC_W = 4;
  function automatic int slot_lo(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-word holding register (clk, reset, flush, load/din in, ready drain, valid/data out); refill wins over drain
module demux_slot #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             ready,
  input  logic [width-1:0] din,
  output logic             valid,
  output logic [width-1:0] data
);
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/demux_1to8_buffered.sv
// demux_1to8_buffered: 1:8 valid/ready distributor (in_valid/in_slt/in_data/in_ready in, eight out_valid/out_data/out_ready slots, registered occupancy)
module demux_1to8_buffered
  import demux_1to8_buffered_pkg::*;
#(
  parameter int width = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [SLT_W-1:0]           in_slt,
  input  logic [width-1:0]           in_data,
  output logic                       in_ready,
  output logic [NUM_SLOTS-1:0]       out_valid,
  output logic [NUM_SLOTS*width-1:0] out_data,
  input  logic [NUM_SLOTS-1:0]       out_ready,
  output logic [OCC_W-1:0]           occupancy
);
  logic [NUM_SLOTS-1:0] load;
  logic [NUM_SLOTS-1:0] nxt_valid;
  assign in_ready = ~out_valid[in_slt] | out_ready[in_slt];
  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    assign load[k] = in_valid & in_ready & (in_slt == SLT_W'(k));
    demux_slot #(.width(width)) u_slot (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .load  (load[k]),
      .ready (out_ready[k]),
      .din   (in_data),
      .valid (out_valid[k]),
      .data  (out_data[slot_lo(k, width) +: width])
    );
  end
  assign nxt_valid = (reset | flush) ? '0 : load | (out_valid & ~out_ready);
  always_ff @(posedge clk) occupancy <= OCC_W'($countones(nxt_valid));
endmodule

// File: tb/tb_demux_1to8_buffered.sv
// tb_demux_1to8_buffered: directed and randomized checks against a slot-array reference model
module tb_demux_1to8_buffered;
  localparam int W = 32;
  logic           clk = 0;
  logic           reset = 1;
  logic           flush = 0;
  logic           in_valid = 0;
  logic [2:0]     in_slt = 0;
  logic [W-1:0]   in_data = 0;
  logic           in_ready;
  logic [7:0]     out_valid;
  logic [8*W-1:0] out_data;
  logic [7:0]     out_ready = 0;
  logic [3:0]     occupancy;
  int n_checks = 0;
  int n_fail = 0;
  bit          mv[8];
  logic [W-1:0] md[8];

  demux_1to8_buffered #(.width(W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_slt(in_slt),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_valid();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = mv[k];
    return v;
  endfunction

  function automatic logic [3:0] exp_occ();
    int c = 0;
    for (int k = 0; k < 8; k++) c += mv[k];
    return 4'(c);
  endfunction

  function automatic logic exp_ready();
    return !mv[in_slt] || out_ready[in_slt];
  endfunction

  task automatic tick();
    bit acc;
    @(posedge clk);
    acc = in_valid && exp_ready();
    if (reset) begin
      for (int k = 0; k < 8; k++) begin
        mv[k] = 0;
        md[k] = '0;
      end
    end else if (flush) begin
      for (int k = 0; k < 8; k++) mv[k] = 0;
    end else begin
      for (int k = 0; k < 8; k++) if (mv[k] && out_ready[k]) mv[k] = 0;
      if (acc) begin
        mv[in_slt] = 1;
        md[in_slt] = in_data;
      end
    end
    #1;
  endtask

  task automatic idle();
    reset = 0; flush = 0; in_valid = 0; out_ready = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic write(input logic [2:0] s, input logic [W-1:0] d);
    in_valid = 1; in_slt = s; in_data = d;
    tick();
    in_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (out_valid !== 8'h00) begin n_fail++; $display("FAIL reset_valid got %h want 00", out_valid); end
    n_checks++;
    if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    n_checks++;
    if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
    for (int s = 0; s < 8; s++) begin
      in_slt = 3'(s);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready slot %0d got %b want 1", s, in_ready); end
    end
  endtask

  task automatic test_write();
    in_valid = 1; in_slt = 3; in_data = 32'hA5A5_0003;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL write_in_ready got %b want 1", in_ready); end
    tick();
    in_valid = 0;
    n_checks++;
    if (out_valid !== 8'h08) begin n_fail++; $display("FAIL write_valid got %h want 08", out_valid); end
    n_checks++;
    if (out_data[3*W +: W] !== 32'hA5A5_0003) begin n_fail++; $display("FAIL write_data got %h want A5A50003", out_data[3*W +: W]); end
    n_checks++;
    if (occupancy !== 4'd1) begin n_fail++; $display("FAIL write_occ got %0d want 1", occupancy); end
    in_valid = 1; in_slt = 3; in_data = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    tick();
    in_valid = 0;
    n_checks++;
    if (out_data[3*W +: W] !== 32'hA5A5_0003) begin n_fail++; $display("FAIL stall_hold got %h want A5A50003", out_data[3*W +: W]); end
  endtask

  task automatic test_refill();
    out_ready = 8'h08; in_valid = 1; in_slt = 3; in_data = 32'h0000_1111;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL refill_in_ready got %b want 1", in_ready); end
    tick();
    idle();
    n_checks++;
    if (out_valid !== 8'h08) begin n_fail++; $display("FAIL refill_valid got %h want 08", out_valid); end
    n_checks++;
    if (out_data[3*W +: W] !== 32'h0000_1111) begin n_fail++; $display("FAIL refill_data got %h want 00001111", out_data[3*W +: W]); end
    n_checks++;
    if (occupancy !== 4'd1) begin n_fail++; $display("FAIL refill_occ got %0d want 1", occupancy); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int k = 0; k < 8; k++) write(3'(k), 32'(k * 16'h0101));
    n_checks++;
    if (out_valid !== 8'hFF || occupancy !== 4'd8) begin n_fail++; $display("FAIL fill_all got %h/%0d want FF/8", out_valid, occupancy); end
    out_ready = 8'h25;
    tick();
    idle();
    n_checks++;
    if (out_valid !== 8'hDA) begin n_fail++; $display("FAIL drain_valid got %h want DA", out_valid); end
    n_checks++;
    if (occupancy !== 4'd5) begin n_fail++; $display("FAIL drain_occ got %0d want 5", occupancy); end
    for (int k = 0; k < 8; k++) if (8'hDA & (8'h1 << k)) begin
      n_checks++;
      if (out_data[k*W +: W] !== 32'(k * 16'h0101)) begin n_fail++; $display("FAIL drain_keep slot %0d got %h want %h", k, out_data[k*W +: W], 32'(k * 16'h0101)); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    write(1, 32'h1111_0001);
    write(6, 32'h6666_0006);
    flush = 1; in_valid = 1; in_slt = 0; in_data = 32'h0BAD_0000;
    tick();
    idle();
    n_checks++;
    if (out_valid !== 8'h00) begin n_fail++; $display("FAIL flush_valid got %h want 00", out_valid); end
    n_checks++;
    if (occupancy !== 4'd0) begin n_fail++; $display("FAIL flush_occ got %0d want 0", occupancy); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 8; k++) write(3'(k), $urandom);
    n_checks++;
    if (out_valid !== 8'hFF) begin n_fail++; $display("FAIL mid_fill got %h want FF", out_valid); end
    out_ready = 8'hFF; in_valid = 1; in_slt = 2; in_data = 32'h1234_5678; reset = 1;
    tick();
    idle();
    n_checks++;
    if (out_valid !== 8'h00 || occupancy !== 4'd0) begin n_fail++; $display("FAIL mid_reset got %h/%0d want 00/0", out_valid, occupancy); end
    n_checks++;
    if (out_data !== '0) begin n_fail++; $display("FAIL mid_reset_data got %h want 0", out_data); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      flush = ($urandom_range(0, 29) == 0);
      in_valid = $urandom_range(0, 3) != 0;
      in_slt = 3'($urandom);
      in_data = $urandom;
      out_ready = 8'($urandom) & 8'($urandom);
      #1;
      n_checks++;
      if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", i, in_ready, exp_ready()); end
      tick();
      n_checks++;
      if (out_valid !== exp_valid()) begin n_fail++; $display("FAIL rnd_valid cyc %0d got %h want %h", i, out_valid, exp_valid()); end
      n_checks++;
      if (occupancy !== exp_occ()) begin n_fail++; $display("FAIL rnd_occ cyc %0d got %0d want %0d", i, occupancy, exp_occ()); end
      for (int k = 0; k < 8; k++) if (mv[k]) begin
        n_checks++;
        if (out_data[k*W +: W] !== md[k]) begin n_fail++; $display("FAIL rnd_data cyc %0d slot %0d got %h want %h", i, k, out_data[k*W +: W], md[k]); end
      end
    end
    idle();
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      mv[k] = 0;
      md[k] = '0;
    end
    #1;
    test_reset();
    test_write();
    test_refill();
    test_fill_drain();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
